// File: rtl/rob_alloc_if.sv
// Dispatch-side handshake bundle for the ROB allocator: per-slot valid/payload in,
// group ready and per-slot ROB tags back out.
interface rob_alloc_if #(
   parameter int DISPATCH_WIDTH = 2,
   parameter int DATA_W         = 32,
   parameter int TAG_W          = 6
);
   logic [DISPATCH_WIDTH-1:0]        valid;
   logic [DISPATCH_WIDTH*DATA_W-1:0] data;
   logic                             ready;
   logic [DISPATCH_WIDTH*TAG_W-1:0]  tag;

   modport master (output valid, output data, input ready, input tag);
   modport slave  (input valid, input data, output ready, output tag);
endinterface

// File: rtl/rob_alloc.sv
// ROB allocation side: assigns consecutive tags to an in-order dispatch group,
// steers each slot onto its ROB FIFO bank and tracks occupancy against retirement.
module rob_alloc #(
   parameter int DISPATCH_WIDTH = 2,
   parameter int RETIRE_WIDTH   = 2,
   parameter int NUM_ROB_ENTS   = 64,
   parameter int NUM_BANKS      = 4,
   parameter int DATA_W         = 32,
   localparam int TAG_W  = $clog2(NUM_ROB_ENTS),
   localparam int CNT_W  = $clog2(NUM_ROB_ENTS + 1),
   localparam int RC_W   = $clog2(RETIRE_WIDTH + 1)
) (
   input  logic                        clk,
   input  logic                        rst,
   rob_alloc_if.slave                  disp,
   input  logic [RC_W-1:0]             retire_cnt,
   input  logic                        flush,
   output logic [NUM_BANKS-1:0]        bank_w_en,
   output logic [NUM_BANKS*DATA_W-1:0] bank_data_in,
   output logic [NUM_ROB_ENTS-1:0]     alloc_mask,
   output logic [CNT_W-1:0]            occupancy,
   output logic                        empty,
   output logic                        full
);
   localparam int NREQ_W = $clog2(DISPATCH_WIDTH + 1);
   localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

   logic [TAG_W-1:0]              wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]              occ_q, occ_d;
   logic [NUM_BANKS-1:0]          bank_w_en_q, bank_w_en_d;
   logic [NUM_BANKS*DATA_W-1:0]   bank_data_q, bank_data_d;
   logic [NUM_ROB_ENTS-1:0]       alloc_mask_q, alloc_mask_d;

   logic [NREQ_W-1:0]             n_req, n_alloc;
   logic                          ready_c;
   logic                          run;
   logic [TAG_W-1:0]              e;
   logic [BANK_W-1:0]             b;
   logic [DISPATCH_WIDTH*TAG_W-1:0] tag_c;

   // Readiness looks only at registered occupancy, so retire credit lands a cycle late.
   assign ready_c = ((CNT_W'(NUM_ROB_ENTS) - occ_q) >= CNT_W'(DISPATCH_WIDTH)) && !flush;

   always_comb begin
      n_req = '0;
      run   = 1'b1;
      for (int i = 0; i < DISPATCH_WIDTH; i++) begin
         run = run & disp.valid[i];
         if (run) n_req = n_req + NREQ_W'(1);
      end
      n_alloc = ready_c ? n_req : '0;
   end

   always_comb begin
      tag_c = '0;
      for (int i = 0; i < DISPATCH_WIDTH; i++)
         tag_c[i*TAG_W +: TAG_W] = wr_ptr_q + TAG_W'(i);
   end

   assign disp.tag   = tag_c;
   assign disp.ready = ready_c;

   always_comb begin
      bank_w_en_d  = '0;
      bank_data_d  = '0;
      alloc_mask_d = '0;
      e            = '0;
      b            = '0;
      for (int i = 0; i < DISPATCH_WIDTH; i++) begin
         if (i < int'(n_alloc)) begin
            e = wr_ptr_q + TAG_W'(i);
            b = BANK_W'(e & TAG_W'(NUM_BANKS - 1));
            bank_w_en_d[b]                   = 1'b1;
            bank_data_d[b*DATA_W +: DATA_W]  = disp.data[i*DATA_W +: DATA_W];
            alloc_mask_d[e]                  = 1'b1;
         end
      end
   end

   // Flush discards everything, including the same-cycle retire count.
   always_comb begin
      wr_ptr_d = wr_ptr_q + TAG_W'(n_alloc);
      occ_d    = occ_q + CNT_W'(n_alloc) - CNT_W'(retire_cnt);
      if (flush) begin
         wr_ptr_d = '0;
         occ_d    = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         occ_q        <= '0;
         bank_w_en_q  <= '0;
         bank_data_q  <= '0;
         alloc_mask_q <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         occ_q        <= occ_d;
         bank_w_en_q  <= bank_w_en_d;
         bank_data_q  <= bank_data_d;
         alloc_mask_q <= alloc_mask_d;
      end
   end

   assign bank_w_en    = bank_w_en_q;
   assign bank_data_in = bank_data_q;
   assign alloc_mask   = alloc_mask_q;
   assign occupancy    = occ_q;
   assign empty        = (occ_q == '0);
   assign full         = (occ_q == CNT_W'(NUM_ROB_ENTS));
endmodule

// File: doc/rob_alloc.md
# rob_alloc

Allocation (write) side of the reorder buffer. It accepts up to DISPATCH_WIDTH in-order instructions per cycle from dispatch and assigns consecutive ROB tags. It rotates each instruction onto the correct one of NUM_BANKS ROB FIFO banks and clears the entry-ready bits of newly allocated entries. It keeps the occupancy count, using the per-cycle retire count reported by the retire side.

## Interface
Parameters:
- DISPATCH_WIDTH, 2, instructions accepted per cycle (≤ NUM_BANKS)
- RETIRE_WIDTH, 2, max entries retired per cycle
- NUM_ROB_ENTS, 64, total entries (power of 2, multiple of NUM_BANKS)
- NUM_BANKS, 4, ROB FIFO banks (power of 2)
- DATA_W, 32, payload bits per entry

Ports (TAG_W = $clog2(NUM_ROB_ENTS), CNT_W = $clog2(NUM_ROB_ENTS+1)):
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- disp_valid  in  DISPATCH_WIDTH  per-slot valid; only the contiguous prefix starting at slot 0 counts
- disp_data  in  DISPATCH_WIDTH*DATA_W  slot i payload at [i*DATA_W +: DATA_W]
- disp_ready  out  1  group may be accepted this cycle
- disp_tag  out  DISPATCH_WIDTH*TAG_W  tag of slot i = (wr_ptr + i) mod NUM_ROB_ENTS, combinational
- retire_cnt  in  $clog2(RETIRE_WIDTH+1)  entries retired this cycle
- flush  in  1  discard all entries (mispredict/exception)
- bank_w_en  out  NUM_BANKS  registered write enable per bank
- bank_data_in  out  NUM_BANKS*DATA_W  registered write data per bank
- alloc_mask  out  NUM_ROB_ENTS  registered one-cycle pulse per allocated entry (clears the ready bit)
- occupancy  out  CNT_W  valid entries
- empty  out  1  occupancy == 0
- full  out  1  occupancy == NUM_ROB_ENTS

## Operation
- n_req = length of the leading run of 1s in disp_valid. Slots after the first 0 are ignored.
- disp_ready = (NUM_ROB_ENTS − occupancy ≥ DISPATCH_WIDTH) && !flush. It depends only on registered state and flush, never on disp_valid.
- Accept: disp_ready && n_req > 0. The group is all-or-nothing, so n_alloc = n_req; otherwise n_alloc = 0.
- Slot i (i < n_alloc) maps to entry e = (wr_ptr + i) mod NUM_ROB_ENTS and bank b = e mod NUM_BANKS. Next cycle it produces bank_w_en[b] = 1, bank_data_in[b] = disp_data slot i, and alloc_mask[e] = 1. At most one slot maps to a given bank, because DISPATCH_WIDTH ≤ NUM_BANKS.
- wr_ptr_next = (wr_ptr + n_alloc) mod NUM_ROB_ENTS, with natural TAG_W wrap.
- occupancy_next = occupancy + n_alloc − retire_cnt. Allocation and retirement in the same cycle are both applied.
- Space freed by retire_cnt is not credited to disp_ready until the next cycle.
- retire_cnt > occupancy is illegal. The bench asserts on it, and the RTL behaviour is undefined.
- flush (highest priority after rst):
  - wr_ptr ← 0 and occupancy ← 0.
  - The same-cycle dispatch is not accepted, and retire_cnt is ignored.
  - bank_w_en and alloc_mask are 0 next cycle.
  - The ROB owner resets the bank FIFOs and its retire pointer on the same flush.
- Reset: wr_ptr = 0, occupancy = 0, bank_w_en = 0, bank_data_in = 0, alloc_mask = 0. Therefore empty = 1, full = 0, and disp_ready = 1 once rst is low.

## Timing
- disp_tag is valid in the same cycle as disp_valid (combinational from wr_ptr), so rename can capture it.
- Bank write and alloc_mask: 1-cycle latency after the accept edge, each asserted for exactly one cycle.
- occupancy, empty and full update on the edge after the accept/retire cycle.
- Registered outputs are 0 in any cycle after a cycle with no accept.
- Back-to-back accepts are allowed every cycle while disp_ready = 1.
- Full stall: when occupancy > NUM_ROB_ENTS − DISPATCH_WIDTH, disp_ready = 0 even if fewer slots are requested.

## Test plan
- **Reset and single dispatch:** rst for 2 cycles, then disp_valid = 2'b01 with data 0xA5 → disp_tag slot 0 = 0. Next cycle: bank_w_en = 4'b0001, bank0 data 0xA5, alloc_mask bit 0, occupancy = 1.
- **Bank rotation and wrap:** fill to wr_ptr = 63 with occupancy 10, then dispatch 2'b11 → tags 63 and 0, bank_w_en = 4'b1001, alloc_mask bits 63 and 0, wr_ptr = 1.
- **Non-prefix valid:** disp_valid = 2'b10 → nothing accepted, bank_w_en = 0, occupancy unchanged.
- **Full boundary:** occupancy = 62 gives disp_ready = 1. Dispatch 2 → occupancy = 64 and full = 1. Then dispatch 1 with occupancy 63 → disp_ready = 0.
- **Simultaneous alloc and retire:** occupancy = 20, dispatch 2, retire_cnt = 2 → occupancy stays 20 and wr_ptr advances by 2.
- **Flush mid-stream:** occupancy = 30 with dispatch 2'b11 and flush in the same cycle → no bank writes, occupancy = 0, wr_ptr = 0, and the next dispatch gets tag 0.
